// File: rtl/flt_pkg.sv
// Shared types, widths and the saturation helper for the motor mixer.
package flt_pkg;

  localparam int unsigned SPD_W = 11;
  localparam int unsigned MIX_W = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Clamp a signed mix sum into the unsigned 11-bit speed range.
  function automatic logic [SPD_W-1:0] sat11(input logic signed [MIX_W-1:0] s);
    logic [SPD_W-1:0] res;
    if (s < 0) begin
      res = '0;
    end else if (s > 13'sd2047) begin
      res = '1;
    end else begin
      res = s[SPD_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/esc_slew_limiter.sv
// One speed channel: moves current toward target by at most SLEW when enabled.
module esc_slew_limiter
  import flt_pkg::*;
#(
  parameter logic [SPD_W-1:0] SLEW = 11'd64
) (
  input  logic [SPD_W-1:0] target,
  input  logic [SPD_W-1:0] current,
  input  logic             en,
  output logic [SPD_W-1:0] next_spd
);

  logic signed [SPD_W:0] diff;
  logic signed [SPD_W:0] slew_s;

  assign diff   = $signed({1'b0, target}) - $signed({1'b0, current});
  assign slew_s = $signed({1'b0, SLEW});

  always_comb begin
    next_spd = current;
    if (en) begin
      if (diff > slew_s) begin
        next_spd = current + SLEW;
      end else if (diff < -slew_s) begin
        next_spd = current - SLEW;
      end else begin
        next_spd = target;
      end
    end
  end

endmodule

// File: rtl/esc_motor_mixer.sv
// Quad motor mixer: arm/calibration sequencing, saturating mix stage and
// slew-limited speed outputs feeding the per-motor ESC PWM stages.
module esc_motor_mixer
  import flt_pkg::*;
#(
  parameter logic [SPD_W-1:0] MIN_RUN = 11'd400,
  parameter logic [SPD_W-1:0] CAL_SPD = 11'd656,
  parameter logic [SPD_W-1:0] SLEW    = 11'd64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             inertial_cal,
  input  logic             vld,
  input  logic [8:0]       thrst,
  input  logic [9:0]       ptch,
  input  logic [9:0]       roll,
  input  logic [9:0]       yaw,
  output logic [SPD_W-1:0] frnt_spd,
  output logic [SPD_W-1:0] bck_spd,
  output logic [SPD_W-1:0] lft_spd,
  output logic [SPD_W-1:0] rght_spd,
  output logic [1:0]       state_o
);

  localparam int unsigned NumMot = 4;

  // Channel order: 0 front, 1 back, 2 left, 3 right.
  state_e                       state_q;
  logic [NumMot-1:0][SPD_W-1:0] spd_q;
  logic [NumMot-1:0][SPD_W-1:0] tgt_q;
  logic                         tgt_vld_q;
  logic [NumMot-1:0][SPD_W-1:0] mix;
  logic [NumMot-1:0][SPD_W-1:0] slew_next;

  logic signed [MIX_W-1:0] base, p_s, r_s, y_s;

  always_comb begin
    base   = $signed({2'b00, MIN_RUN}) + $signed({4'b0000, thrst});
    p_s    = {{(MIX_W-10){ptch[9]}}, ptch};
    r_s    = {{(MIX_W-10){roll[9]}}, roll};
    y_s    = {{(MIX_W-10){yaw[9]}}, yaw};
    mix[0] = sat11(base + p_s - y_s);
    mix[1] = sat11(base - p_s - y_s);
    mix[2] = sat11(base + r_s + y_s);
    mix[3] = sat11(base - r_s + y_s);
  end

  for (genvar g = 0; g < NumMot; g++) begin : g_slew
    esc_slew_limiter #(
      .SLEW(SLEW)
    ) u_slew (
      .target  (tgt_q[g]),
      .current (spd_q[g]),
      .en      (tgt_vld_q),
      .next_spd(slew_next[g])
    );
  end

  // Outputs are decided together with the state transition so that IDLE/CAL
  // speeds appear on the same edge the new state does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      spd_q     <= '0;
      tgt_q     <= '0;
      tgt_vld_q <= 1'b0;
    end else begin
      tgt_vld_q <= 1'b0;
      if (!arm) begin
        state_q <= IDLE;
        spd_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (inertial_cal) begin
              state_q <= CAL;
              spd_q   <= {NumMot{CAL_SPD}};
            end else begin
              state_q <= RUN;
            end
          end
          CAL: begin
            spd_q <= {NumMot{CAL_SPD}};
            if (!inertial_cal) begin
              state_q <= RUN;
            end
          end
          RUN: begin
            if (inertial_cal) begin
              state_q <= CAL;
              spd_q   <= {NumMot{CAL_SPD}};
            end else begin
              if (vld) begin
                tgt_q <= mix;
              end
              tgt_vld_q <= vld;
              spd_q     <= slew_next;
            end
          end
          default: begin
            state_q <= IDLE;
            spd_q   <= '0;
          end
        endcase
      end
    end
  end

  assign frnt_spd = spd_q[0];
  assign bck_spd  = spd_q[1];
  assign lft_spd  = spd_q[2];
  assign rght_spd = spd_q[3];
  assign state_o  = state_q;

endmodule

// File: tb/tb_esc_motor_mixer.sv
// Directed bench for esc_motor_mixer; a second instance with MIN_RUN=1024
// exercises high-side saturation.
module tb_esc_motor_mixer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        arm = 1'b0;
  logic        inertial_cal = 1'b0;
  logic        vld = 1'b0;
  logic [8:0]  thrst = '0;
  logic [9:0]  ptch = '0;
  logic [9:0]  roll = '0;
  logic [9:0]  yaw = '0;
  logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  logic [10:0] frnt_hi, bck_hi, lft_hi, rght_hi;
  logic [1:0]  state_o, state_hi;

  int n_checks = 0;
  int n_fail = 0;

  int exp_f [10] = '{64, 128, 192, 256, 320, 384, 448, 512, 540, 540};
  int exp_b [10] = '{64, 128, 192, 256, 320, 384, 440, 440, 440, 440};
  int exp_l [10] = '{64, 128, 192, 256, 320, 384, 448, 490, 490, 490};
  int exp_r [10] = '{64, 128, 192, 256, 320, 384, 448, 512, 530, 530};

  always #5 clk = ~clk;

  esc_motor_mixer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .inertial_cal(inertial_cal),
    .vld         (vld),
    .thrst       (thrst),
    .ptch        (ptch),
    .roll        (roll),
    .yaw         (yaw),
    .frnt_spd    (frnt_spd),
    .bck_spd     (bck_spd),
    .lft_spd     (lft_spd),
    .rght_spd    (rght_spd),
    .state_o     (state_o)
  );

  esc_motor_mixer #(
    .MIN_RUN(11'd1024)
  ) dut_hi (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .inertial_cal(inertial_cal),
    .vld         (vld),
    .thrst       (thrst),
    .ptch        (ptch),
    .roll        (roll),
    .yaw         (yaw),
    .frnt_spd    (frnt_hi),
    .bck_spd     (bck_hi),
    .lft_spd     (lft_hi),
    .rght_spd    (rght_hi),
    .state_o     (state_hi)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    arm = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({frnt_spd, bck_spd, lft_spd, rght_spd, state_o} !== 46'd0) begin
      $display("FAIL reset: got %0d/%0d/%0d/%0d state %0d, expected 0/0/0/0 state 0",
               frnt_spd, bck_spd, lft_spd, rght_spd, state_o);
      n_fail++;
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_arm_run;
    arm = 1'b1;
    inertial_cal = 1'b0;
    tick();
    n_checks++;
    if (state_o !== 2'd2) begin
      $display("FAIL arm_state: got %0d, expected 2", state_o);
      n_fail++;
    end
    tick(); tick(); tick();
    n_checks++;
    if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== 44'd0) begin
      $display("FAIL run_no_vld: got %0d/%0d/%0d/%0d, expected 0/0/0/0",
               frnt_spd, bck_spd, lft_spd, rght_spd);
      n_fail++;
    end
  endtask

  task automatic test_ramp;
    thrst = 9'd100; ptch = 10'sd50; roll = -10'sd20; yaw = 10'sd10;
    vld = 1'b1;
    tick();
    n_checks++;
    if (frnt_spd !== 11'd0) begin
      $display("FAIL ramp_latency: got %0d one edge after vld, expected 0", frnt_spd);
      n_fail++;
    end
    for (int s = 0; s < 10; s++) begin
      tick();
      n_checks++;
      if (frnt_spd !== 11'(exp_f[s]) || bck_spd !== 11'(exp_b[s]) ||
          lft_spd !== 11'(exp_l[s]) || rght_spd !== 11'(exp_r[s])) begin
        $display("FAIL ramp_step%0d: got %0d/%0d/%0d/%0d, expected %0d/%0d/%0d/%0d", s + 1,
                 frnt_spd, bck_spd, lft_spd, rght_spd, exp_f[s], exp_b[s], exp_l[s], exp_r[s]);
        n_fail++;
      end
    end
    vld = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== {11'd540, 11'd440, 11'd490, 11'd530}) begin
      $display("FAIL ramp_hold: got %0d/%0d/%0d/%0d, expected 540/440/490/530",
               frnt_spd, bck_spd, lft_spd, rght_spd);
      n_fail++;
    end
  endtask

  task automatic test_cal;
    inertial_cal = 1'b1;
    tick();
    n_checks++;
    if ({frnt_spd, bck_spd, lft_spd, rght_spd, state_o} !==
        {11'd656, 11'd656, 11'd656, 11'd656, 2'd1}) begin
      $display("FAIL cal_entry: got %0d/%0d/%0d/%0d state %0d, expected 656 x4 state 1",
               frnt_spd, bck_spd, lft_spd, rght_spd, state_o);
      n_fail++;
    end
    thrst = '0; ptch = '0; roll = '0; yaw = '0;
    vld = 1'b1;
    tick();
    inertial_cal = 1'b0;
    tick();
    vld = 1'b0;
    tick(); tick();
    n_checks++;
    if ({frnt_spd, bck_spd, lft_spd, rght_spd, state_o} !==
        {11'd656, 11'd656, 11'd656, 11'd656, 2'd2}) begin
      $display("FAIL cal_vld_ignored: got %0d/%0d/%0d/%0d state %0d, expected 656 x4 state 2",
               frnt_spd, bck_spd, lft_spd, rght_spd, state_o);
      n_fail++;
    end
    vld = 1'b1;
    tick();
    vld = 1'b0;
    tick();
    n_checks++;
    if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== {11'd592, 11'd592, 11'd592, 11'd592}) begin
      $display("FAIL cal_first_step: got %0d/%0d/%0d/%0d, expected 592 x4",
               frnt_spd, bck_spd, lft_spd, rght_spd);
      n_fail++;
    end
    tick();
    n_checks++;
    if (frnt_spd !== 11'd592) begin
      $display("FAIL cal_hold: got %0d, expected 592", frnt_spd);
      n_fail++;
    end
    vld = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) begin
      tick();
      n_checks++;
      if (frnt_spd !== 11'(528 - 64 * s)) begin
        $display("FAIL cal_descend%0d: got %0d, expected %0d", s + 2, frnt_spd, 528 - 64 * s);
        n_fail++;
      end
    end
    vld = 1'b0;
    tick(); tick();
    n_checks++;
    if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== {11'd400, 11'd400, 11'd400, 11'd400}) begin
      $display("FAIL cal_settle: got %0d/%0d/%0d/%0d, expected 400 x4",
               frnt_spd, bck_spd, lft_spd, rght_spd);
      n_fail++;
    end
  endtask

  task automatic test_sat_low;
    thrst = '0; ptch = -10'sd512; roll = '0; yaw = 10'sd511;
    vld = 1'b1;
    repeat (12) tick();
    vld = 1'b0;
    tick();
    n_checks++;
    if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== {11'd0, 11'd401, 11'd911, 11'd911}) begin
      $display("FAIL sat_low: got %0d/%0d/%0d/%0d, expected 0/401/911/911",
               frnt_spd, bck_spd, lft_spd, rght_spd);
      n_fail++;
    end
  endtask

  task automatic test_sat_high;
    logic [10:0] prev;
    thrst = 9'd511; ptch = 10'sd511; roll = '0; yaw = -10'sd512;
    vld = 1'b1;
    prev = frnt_hi;
    for (int s = 0; s < 40; s++) begin
      tick();
      n_checks++;
      if (frnt_hi < prev) begin
        $display("FAIL sat_high_wrap%0d: got %0d after %0d, expected non-decreasing", s,
                 frnt_hi, prev);
        n_fail++;
      end
      prev = frnt_hi;
    end
    vld = 1'b0;
    tick();
    n_checks++;
    if ({frnt_hi, bck_hi, lft_hi, rght_hi} !== {11'd2047, 11'd1536, 11'd1023, 11'd1023}) begin
      $display("FAIL sat_high: got %0d/%0d/%0d/%0d, expected 2047/1536/1023/1023",
               frnt_hi, bck_hi, lft_hi, rght_hi);
      n_fail++;
    end
    n_checks++;
    if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== {11'd1934, 11'd912, 11'd399, 11'd399}) begin
      $display("FAIL sat_high_base: got %0d/%0d/%0d/%0d, expected 1934/912/399/399",
               frnt_spd, bck_spd, lft_spd, rght_spd);
      n_fail++;
    end
  endtask

  task automatic test_abort;
    thrst = 9'd100; ptch = '0; roll = '0; yaw = '0;
    vld = 1'b1;
    repeat (30) tick();
    n_checks++;
    if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== {11'd500, 11'd500, 11'd500, 11'd500}) begin
      $display("FAIL abort_pre: got %0d/%0d/%0d/%0d, expected 500 x4",
               frnt_spd, bck_spd, lft_spd, rght_spd);
      n_fail++;
    end
    thrst = 9'd300;
    tick();
    arm = 1'b0;
    tick();
    n_checks++;
    if ({frnt_spd, bck_spd, lft_spd, rght_spd, state_o} !== 46'd0) begin
      $display("FAIL abort_edge: got %0d/%0d/%0d/%0d state %0d, expected 0 x4 state 0",
               frnt_spd, bck_spd, lft_spd, rght_spd, state_o);
      n_fail++;
    end
    vld = 1'b0;
    tick(); tick();
    n_checks++;
    if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== 44'd0) begin
      $display("FAIL abort_hold: got %0d/%0d/%0d/%0d, expected 0 x4",
               frnt_spd, bck_spd, lft_spd, rght_spd);
      n_fail++;
    end
    arm = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if ({frnt_spd, bck_spd, lft_spd, rght_spd, state_o} !== {44'd0, 2'd2}) begin
      $display("FAIL abort_rearm: got %0d/%0d/%0d/%0d state %0d, expected 0 x4 state 2",
               frnt_spd, bck_spd, lft_spd, rght_spd, state_o);
      n_fail++;
    end
  endtask

  task automatic test_async_reset;
    thrst = 9'd100;
    vld = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (frnt_spd !== 11'd192) begin
      $display("FAIL async_pre: got %0d, expected 192", frnt_spd);
      n_fail++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({frnt_spd, bck_spd, lft_spd, rght_spd, state_o, state_hi} !== 48'd0) begin
      $display("FAIL async_reset: got %0d/%0d/%0d/%0d state %0d/%0d, expected all 0",
               frnt_spd, bck_spd, lft_spd, rght_spd, state_o, state_hi);
      n_fail++;
    end
    vld = 1'b0;
    arm = 1'b0;
    #10 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_arm_run();
    test_ramp();
    test_cal();
    test_sat_low();
    test_sat_high();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
